// File: rtl/reset_sequencer.sv
// ============================================================================
//  Module      : reset_sequencer
//  Description : Releases the SoC subsystems in a fixed order after power-on
//                or warm reset: data memory (with init handshake), then the
//                GEMM accelerator, then the RISC-V core. A software warm reset
//                first waits (bounded) for the accelerator to go idle.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 12,
    parameter int INIT_TIMEOUT    = 1024,
    parameter int QUIESCE_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soft_rst_req,
    input  logic       mem_init_done,
    input  logic       acc_idle,
    output logic       mem_rst_n,
    output logic       mem_init_start,
    output logic       acc_rst_n,
    output logic       core_rst_n,
    output logic       ready,
    output logic       init_fault,
    output logic       quiesce_to,
    output logic [2:0] state_o
);

    // ------------------------------------------------------------------------
    // Counter sizing: one counter serves every timed state, so it is sized for
    // the largest of the three limits. It only ever needs to reach limit-1.
    // ------------------------------------------------------------------------
    localparam int MAX_HI   = (HOLD_CYCLES > INIT_TIMEOUT) ? HOLD_CYCLES : INIT_TIMEOUT;
    localparam int MAX_LIM  = (MAX_HI > QUIESCE_TIMEOUT) ? MAX_HI : QUIESCE_TIMEOUT;
    localparam int CNT_W    = ($clog2(MAX_LIM) < 1) ? 1 : $clog2(MAX_LIM);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] QUIESCE_LAST = CNT_W'(QUIESCE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_HOLD     = 3'd1,
        ST_MEM_INIT = 3'd2,
        ST_ACC_REL  = 3'd3,
        ST_RUN      = 3'd4,
        ST_QUIESCE  = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic              released;

    logic              mem_rst_n_next;
    logic              mem_init_start_next;
    logic              acc_rst_n_next;
    logic              core_rst_n_next;
    logic              ready_next;
    logic              init_fault_next;
    logic              quiesce_to_next;
    logic              quiesce_forced;

    // ------------------------------------------------------------------------
    // Reset-release synchronizer: assertion is asynchronous (clear), release
    // ripples a constant 1 through SYNC_STAGES flops on the core clock.
    // ------------------------------------------------------------------------
    generate
        if (SYNC_STAGES > 1) begin : g_sync_multi
            // Shift a one through the chain once rst_n is released.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_ff <= '0;
                end else begin
                    sync_ff <= {sync_ff[SYNC_STAGES-2:0], 1'b1};
                end
            end
        end else begin : g_sync_single
            // Degenerate depth kept only so an out-of-range value still builds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_ff <= '0;
                end else begin
                    sync_ff <= 1'b1;
                end
            end
        end
    endgenerate

    assign released = sync_ff[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Next-state and next-output decode. Outputs are computed from the state
    // being entered so the registered outputs change on the entering edge.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next          = state;
        quiesce_forced      = 1'b0;
        mem_rst_n_next      = 1'b0;
        mem_init_start_next = 1'b0;
        acc_rst_n_next      = 1'b0;
        core_rst_n_next     = 1'b0;
        ready_next          = 1'b0;

        case (state)
            ST_RESET: begin
                if (released) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_next = ST_MEM_INIT;
                end
            end
            ST_MEM_INIT: begin
                // A completion in the timeout cycle still counts as success.
                if (mem_init_done) begin
                    state_next = ST_ACC_REL;
                end else if (cnt == INIT_LAST) begin
                    state_next = ST_FAULT;
                end
            end
            ST_ACC_REL: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (soft_rst_req) begin
                    state_next = ST_QUIESCE;
                end
            end
            ST_QUIESCE: begin
                // Idle in the timeout cycle is a clean quiesce, not a forced one.
                if (acc_idle) begin
                    state_next = ST_HOLD;
                end else if (cnt == QUIESCE_LAST) begin
                    state_next     = ST_HOLD;
                    quiesce_forced = 1'b1;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase

        // Reset levels are a pure function of the state being entered; this
        // keeps memory-before-accelerator-before-core true in every state.
        case (state_next)
            ST_MEM_INIT: begin
                mem_rst_n_next = 1'b1;
            end
            ST_ACC_REL: begin
                mem_rst_n_next = 1'b1;
                acc_rst_n_next = 1'b1;
            end
            ST_RUN: begin
                mem_rst_n_next  = 1'b1;
                acc_rst_n_next  = 1'b1;
                core_rst_n_next = 1'b1;
                ready_next      = 1'b1;
            end
            ST_QUIESCE: begin
                mem_rst_n_next = 1'b1;
                acc_rst_n_next = 1'b1;
            end
            ST_FAULT: begin
                mem_rst_n_next = 1'b1;
            end
            default: begin
                mem_rst_n_next = 1'b0;
            end
        endcase

        // Start pulse lasts exactly the first MEM_INIT cycle.
        mem_init_start_next = (state_next == ST_MEM_INIT) && (state != ST_MEM_INIT);

        // Sticky diagnostics; only rst_n clears them.
        init_fault_next = init_fault | (state_next == ST_FAULT);
        quiesce_to_next = quiesce_to | quiesce_forced;
    end

    // ------------------------------------------------------------------------
    // Shared cycle counter: restarts on every state change, saturates rather
    // than wrapping so a parked state can never re-trigger a compare.
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_next = cnt;
        if (state_next != state) begin
            cnt_next = '0;
        end else if (cnt != CNT_SAT) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // State, counter and all outputs registered; rst_n forces the safe state
    // immediately without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_RESET;
            cnt            <= '0;
            mem_rst_n      <= 1'b0;
            mem_init_start <= 1'b0;
            acc_rst_n      <= 1'b0;
            core_rst_n     <= 1'b0;
            ready          <= 1'b0;
            init_fault     <= 1'b0;
            quiesce_to     <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            mem_rst_n      <= mem_rst_n_next;
            mem_init_start <= mem_init_start_next;
            acc_rst_n      <= acc_rst_n_next;
            core_rst_n     <= core_rst_n_next;
            ready          <= ready_next;
            init_fault     <= init_fault_next;
            quiesce_to     <= quiesce_to_next;
        end
    end

    assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Directed bench for reset_sequencer: cold boot timing, init
//                timeout, same-cycle races, warm reset (clean and forced) and
//                asynchronous reset mid-sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reset_sequencer;

    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_HOLD  = 3'd1;
    localparam logic [2:0] S_INIT  = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_QUI   = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       soft_rst_req;
    logic       mem_init_done;
    logic       acc_idle;
    logic       mem_rst_n;
    logic       mem_init_start;
    logic       acc_rst_n;
    logic       core_rst_n;
    logic       ready;
    logic       init_fault;
    logic       quiesce_to;
    logic [2:0] state_o;
    logic [9:0] obs;

    int errors = 0;
    int checks = 0;

    string      tag_q[$];
    logic [9:0] exp_q[$];

    reset_sequencer #(
        .SYNC_STAGES    (2),
        .HOLD_CYCLES    (12),
        .INIT_TIMEOUT   (16),
        .QUIESCE_TIMEOUT(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .soft_rst_req  (soft_rst_req),
        .mem_init_done (mem_init_done),
        .acc_idle      (acc_idle),
        .mem_rst_n     (mem_rst_n),
        .mem_init_start(mem_init_start),
        .acc_rst_n     (acc_rst_n),
        .core_rst_n    (core_rst_n),
        .ready         (ready),
        .init_fault    (init_fault),
        .quiesce_to    (quiesce_to),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    assign obs = {mem_rst_n, mem_init_start, acc_rst_n, core_rst_n, ready,
                  init_fault, quiesce_to, state_o};

    // Expected output vector for a given state plus pulse/sticky bits.
    function automatic logic [9:0] ex(input logic [2:0] st, input logic start,
                                      input logic flt, input logic qto);
        logic m, a, c, r;
        m = 1'b0; a = 1'b0; c = 1'b0; r = 1'b0;
        case (st)
            S_INIT:  m = 1'b1;
            S_ACC:   begin m = 1'b1; a = 1'b1; end
            S_RUN:   begin m = 1'b1; a = 1'b1; c = 1'b1; r = 1'b1; end
            S_QUI:   begin m = 1'b1; a = 1'b1; end
            S_FAULT: m = 1'b1;
            default: m = 1'b0;
        endcase
        return {m, start, a, c, r, flt, qto, st};
    endfunction

    task automatic push_exp(input string tag, input logic [9:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        string      t;
        logic [9:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%b expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%b expected=%b", t, obs, e);
            end
        end
    endtask

    // Push expectation, let one active edge pass, compare 1 ns later.
    task automatic cyc(input string tag, input logic [9:0] e);
        push_exp(tag, e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic cycn(input int n, input string tag, input logic [9:0] e);
        for (int i = 0; i < n; i++) begin
            cyc(tag, e);
        end
    endtask

    task automatic now_chk(input string tag, input logic [9:0] e);
        push_exp(tag, e);
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        soft_rst_req  = 1'b0;
        mem_init_done = 1'b0;
        acc_idle      = 1'b1;

        // Reset state, before any clock edge and while held.
        #2;
        now_chk("reset_no_clock", ex(S_RESET, 0, 0, 0));
        cycn(2, "reset_held", ex(S_RESET, 0, 0, 0));

        // Cold boot: rst_n rises before edge 1, memory released at edge 15.
        rst_n = 1'b1;
        cycn(2, "cold_sync", ex(S_RESET, 0, 0, 0));
        cycn(12, "cold_hold", ex(S_HOLD, 0, 0, 0));
        cyc("cold_mem_rel_e15", ex(S_INIT, 1, 0, 0));
        cycn(3, "cold_init_wait", ex(S_INIT, 0, 0, 0));
        mem_init_done = 1'b1;
        cyc("cold_acc_rel_e19", ex(S_ACC, 0, 0, 0));
        mem_init_done = 1'b0;
        cyc("cold_run_e20", ex(S_RUN, 0, 0, 0));
        cycn(3, "cold_run_stay", ex(S_RUN, 0, 0, 0));

        // Warm reset, accelerator busy for 5 cycles then idle.
        soft_rst_req = 1'b1;
        acc_idle     = 1'b0;
        cyc("warm_core_off", ex(S_QUI, 0, 0, 0));
        soft_rst_req = 1'b0;
        cycn(4, "warm_quiesce", ex(S_QUI, 0, 0, 0));
        acc_idle = 1'b1;
        cyc("warm_mem_acc_off", ex(S_HOLD, 0, 0, 0));
        cycn(10, "warm_hold", ex(S_HOLD, 0, 0, 0));
        mem_init_done = 1'b1;
        cyc("warm_hold_last", ex(S_HOLD, 0, 0, 0));
        cyc("warm_mem_rel", ex(S_INIT, 1, 0, 0));
        cyc("warm_done_in_start_cycle", ex(S_ACC, 0, 0, 0));
        mem_init_done = 1'b0;
        cyc("warm_run", ex(S_RUN, 0, 0, 0));

        // Warm reset where idle arrives exactly in the timeout cycle.
        soft_rst_req = 1'b1;
        acc_idle     = 1'b0;
        cyc("qsame_enter", ex(S_QUI, 0, 0, 0));
        soft_rst_req = 1'b0;
        cycn(7, "qsame_wait", ex(S_QUI, 0, 0, 0));
        acc_idle = 1'b1;
        cyc("qsame_no_flag", ex(S_HOLD, 0, 0, 0));
        cycn(11, "qsame_hold", ex(S_HOLD, 0, 0, 0));
        cyc("isame_start", ex(S_INIT, 1, 0, 0));
        // Done first seen in the 16th MEM_INIT cycle (timeout cycle).
        cycn(15, "isame_wait", ex(S_INIT, 0, 0, 0));
        mem_init_done = 1'b1;
        cyc("isame_done_wins", ex(S_ACC, 0, 0, 0));
        mem_init_done = 1'b0;
        cyc("isame_run", ex(S_RUN, 0, 0, 0));

        // Forced warm reset by quiesce timeout; flag survives the re-boot.
        soft_rst_req = 1'b1;
        acc_idle     = 1'b0;
        cyc("qto_enter", ex(S_QUI, 0, 0, 0));
        soft_rst_req = 1'b0;
        cycn(7, "qto_wait", ex(S_QUI, 0, 0, 0));
        cyc("qto_forced", ex(S_HOLD, 0, 0, 1));
        acc_idle     = 1'b1;
        soft_rst_req = 1'b1;
        cycn(11, "qto_hold_soft_ignored", ex(S_HOLD, 0, 0, 1));
        soft_rst_req = 1'b0;
        cyc("qto_mem_rel", ex(S_INIT, 1, 0, 1));
        mem_init_done = 1'b1;
        cyc("qto_acc_rel", ex(S_ACC, 0, 0, 1));
        mem_init_done = 1'b0;
        cycn(2, "qto_run_sticky", ex(S_RUN, 0, 0, 1));

        // Clean warm reset, then memory init never completes -> FAULT.
        soft_rst_req = 1'b1;
        cyc("flt_quiesce", ex(S_QUI, 0, 0, 1));
        soft_rst_req = 1'b0;
        cyc("flt_hold_entry", ex(S_HOLD, 0, 0, 1));
        cycn(11, "flt_hold", ex(S_HOLD, 0, 0, 1));
        cyc("flt_start", ex(S_INIT, 1, 0, 1));
        cycn(15, "flt_wait", ex(S_INIT, 0, 0, 1));
        cyc("flt_entry", ex(S_FAULT, 0, 1, 1));
        soft_rst_req = 1'b1;
        cycn(3, "flt_stay", ex(S_FAULT, 0, 1, 1));
        soft_rst_req = 1'b0;

        // 1 ns rst_n pulse away from any edge clears everything, sticky too.
        #2;
        rst_n = 1'b0;
        #0.5;
        now_chk("flt_async_clear", ex(S_RESET, 0, 0, 0));
        #0.5;
        rst_n = 1'b1;
        cycn(2, "reboot_sync", ex(S_RESET, 0, 0, 0));
        cycn(12, "reboot_hold", ex(S_HOLD, 0, 0, 0));
        cyc("reboot_mem_rel", ex(S_INIT, 1, 0, 0));
        cycn(2, "reboot_init", ex(S_INIT, 0, 0, 0));

        // Same pulse mid-MEM_INIT: no partial release, restart from edge 1.
        #2;
        rst_n = 1'b0;
        #0.5;
        now_chk("mid_init_async_clear", ex(S_RESET, 0, 0, 0));
        #0.5;
        rst_n = 1'b1;
        cycn(2, "restart_sync", ex(S_RESET, 0, 0, 0));
        cycn(12, "restart_hold", ex(S_HOLD, 0, 0, 0));
        cyc("restart_mem_rel", ex(S_INIT, 1, 0, 0));
        mem_init_done = 1'b1;
        cyc("restart_acc_rel", ex(S_ACC, 0, 0, 0));
        mem_init_done = 1'b0;
        cyc("restart_run", ex(S_RUN, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
